// File: rtl/xunit_msched.sv
// SHA-256 message schedule generator: loads M0..M15 after a programmable delay and expands W16..W63.
// Optional K-constant ROM on out1 is enabled by defining XUNIT_MSCHED_KROM_EN.
module xunit_msched #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [7:0]        delay0,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              valid,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        LOAD   = 2'd2,
        EXPAND = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        dcnt_r;
    logic [5:0]        t_r;
    logic [DATA_W-1:0] win_r [0:15];
    logic [DATA_W-1:0] w_new_s;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

`ifdef XUNIT_MSCHED_KROM_EN
    localparam logic [31:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_lookup(input logic [5:0] idx);
        return K_ROM[idx];
    endfunction
`else
    function automatic logic [31:0] k_lookup(input logic [5:0] idx);
        return (idx == 6'd0) ? 32'h0000_0000 : 32'h0000_0000;
    endfunction
`endif

    // Next-state decode and the word that enters the window this cycle
    always_comb begin
        state_nxt_s = state_r;
        if (state_r == LOAD) begin
            w_new_s = in0;
        end else begin
            // win_r[i] holds W(t-1-i)
            w_new_s = sig1(win_r[1]) + win_r[6] + sig0(win_r[14]) + win_r[15];
        end
        case (state_r)
            IDLE:    state_nxt_s = IDLE;
            DELAY:   state_nxt_s = (dcnt_r <= 8'd1) ? LOAD : DELAY;
            LOAD:    state_nxt_s = (t_r == 6'd15) ? EXPAND : LOAD;
            EXPAND:  state_nxt_s = (t_r == 6'd63) ? IDLE : EXPAND;
            default: state_nxt_s = IDLE;
        endcase
        if (run) begin
            state_nxt_s = (delay0 != 8'd0) ? DELAY : LOAD;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, window and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_r <= 8'd0;
            t_r    <= 6'd0;
            out0   <= '0;
            out1   <= '0;
            valid  <= 1'b0;
            done   <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= '0;
            end
        end else if (run) begin
            dcnt_r <= delay0;
            t_r    <= 6'd0;
            valid  <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state_r)
                DELAY: begin
                    dcnt_r <= dcnt_r - 8'd1;
                    valid  <= 1'b0;
                end
                LOAD, EXPAND: begin
                    out0     <= w_new_s;
                    out1     <= k_lookup(t_r);
                    valid    <= 1'b1;
                    win_r[0] <= w_new_s;
                    for (int i = 1; i < 16; i++) begin
                        win_r[i] <= win_r[i-1];
                    end
                    // t saturates at 63; only a new run clears it
                    if (t_r != 6'd63) begin
                        t_r <= t_r + 6'd1;
                    end
                    if (state_r == EXPAND && t_r == 6'd63) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/xunit_msched.md
XUNIT_MSCHED -- requirements
Module: xunit_msched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port run  input  1  one-cycle start pulse for one 64-word schedule.
REQ-005 SHALL have port in0  input  DATA_W  message word stream, big-endian SHA-256 words M0..M15.
REQ-006 SHALL have port delay0  input  8  cycles to wait after run before sampling M0.
REQ-007 SHALL have port out0  output  DATA_W  current schedule word W_t, registered.
REQ-008 SHALL have port out1  output  DATA_W  round constant K_t aligned with out0 (see Configuration).
REQ-009 SHALL have port valid  output  1  high for each cycle out0 holds a new W_t.
REQ-010 SHALL have port done  output  1  high when idle; low from the cycle after run until W63 is presented.

Function
REQ-011 SHALL implement FSM states IDLE, DELAY, LOAD, EXPAND.
REQ-012 SHALL, on run in any state, load delay counter with delay0, clear t counter (6 bits), enter DELAY if delay0!=0, else LOAD.
REQ-013 SHALL, in DELAY, decrement counter each cycle; on counter==1 enter LOAD.
REQ-014 SHALL, in LOAD, sample in0 each cycle for 16 cycles (t=0..15), write it to out0 one cycle later, and shift it into a 16-entry window.
REQ-015 SHALL, in EXPAND (t=16..63), compute W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16 mod 2^32, register it to out0 and shift it into the window; in0 ignored.
REQ-016 SHALL use s0(x)=ROTR7^ROTR18^SHR3 and s1(x)=ROTR17^ROTR19^SHR10.
REQ-017 SHALL assert valid exactly 64 cycles, contiguous, starting one cycle after the first LOAD cycle.
REQ-018 SHALL return to IDLE and raise done in the same cycle W63 is presented on out0 with valid high.
REQ-019 SHALL hold out0/out1 at last value while not valid.
REQ-020 SHALL, on run while busy, abandon the current schedule and restart per REQ-012; no further valid words from the old schedule.
REQ-021 SHALL make t wrap-free: EXPAND ends at t=63, never overflowing into t=0 without a new run.

Reset
REQ-022 SHALL, on rst high at a clock edge, set state IDLE, out0=0, out1=0, valid=0, done=1, counters and window cleared.
REQ-023 SHALL give rst priority over run in the same cycle; reset mid-schedule discards it with no further valid pulses.

Configuration
REQ-024 SHALL, with macro XUNIT_MSCHED_KROM_EN defined, include a 64-entry SHA-256 K ROM indexed by t, registered to out1 in the same cycle as out0.
REQ-025 SHALL, without XUNIT_MSCHED_KROM_EN, tie out1 to 0 and include no ROM; all other behaviour identical.

Verification
REQ-026 SHALL verify: "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), delay0=0 -> W0..W15 equal inputs, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, 64 valid cycles, done high after W63.
REQ-027 SHALL verify: delay0=5, run pulse -> first valid exactly 7 cycles after run, in0 sampled on cycle 6 only.
REQ-028 SHALL verify: second run after 30 valid words -> valid drops, restarts, then 64 fresh valid words match reference model.
REQ-029 SHALL verify: rst asserted at t=40 -> next cycle out0=0, valid=0, done=1, no further valid until new run.
REQ-030 SHALL verify: with XUNIT_MSCHED_KROM_EN -> out1=0x428A2F98 with W0, out1=0xC67178F2 with W63; without -> out1=0 throughout.
